// File: rtl/host_port_arbiter.sv
// Round-robin arbiter sharing one memory-controller command port.
// Optional watchdog: define HPA_TIMEOUT_EN to abort stalled transactions.
module host_port_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_rd_valid,
    output logic [DATA_W-1:0]         req_rd_data,
    output logic                      req_err,
    output logic [1:0]                mc_op,
    output logic [ADDR_W-1:0]         mc_addr,
    output logic [DATA_W-1:0]         mc_wr_data,
    input  logic [DATA_W-1:0]         mc_rd_data,
    input  logic                      mc_ready,
    input  logic                      mc_tx_done,
    input  logic                      mc_rd_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_WR = 2'b10;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   win;
    logic [1:0]         cur_op;
    logic [NUM_REQ-1:0] active;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W:0]     cand;
    logic               found;
    logic [1:0]         sel_op;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               tmo_hit;

`ifdef HPA_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_comb begin
        active = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            active[k] = (req_op[2*k +: 2] == OP_RD) || (req_op[2*k +: 2] == OP_WR);
        end
    end

    // Search starts just past the last winner so grants rotate fairly.
    always_comb begin
        found = 1'b0;
        sel   = last_grant;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && active[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_op   = req_op[2*int'(sel) +: 2];
        sel_addr = req_addr[ADDR_W*int'(sel) +: ADDR_W];
        sel_data = req_wr_data[DATA_W*int'(sel) +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= LAST_IDX;
            win          <= '0;
            cur_op       <= 2'b00;
            req_gnt      <= '0;
            req_done     <= '0;
            req_rd_valid <= '0;
            req_rd_data  <= '0;
            req_err      <= 1'b0;
            mc_op        <= 2'b00;
            mc_addr      <= '0;
            mc_wr_data   <= '0;
`ifdef HPA_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            req_rd_valid <= '0;
            case (state)
                IDLE: begin
                    if (found && mc_ready) begin
                        win        <= sel;
                        cur_op     <= sel_op;
                        mc_op      <= sel_op;
                        mc_addr    <= sel_addr;
                        mc_wr_data <= sel_data;
                        req_gnt    <= onehot(sel);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mc_op <= 2'b00;
                    state <= WAIT;
`ifdef HPA_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    // A timeout abort never delivers read data.
                    if (mc_rd_valid && cur_op == OP_RD &&
                        (mc_tx_done || !tmo_hit)) begin
                        req_rd_data  <= mc_rd_data;
                        req_rd_valid <= onehot(win);
                    end
                    if (mc_tx_done) begin
                        req_done <= onehot(win);
                        req_err  <= 1'b0;
                        state    <= DONE;
                    end else if (tmo_hit) begin
                        req_done <= onehot(win);
                        req_err  <= 1'b1;
                        state    <= DONE;
                    end
`ifdef HPA_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
`endif
                end
                DONE: begin
                    req_done   <= '0;
                    req_err    <= 1'b0;
                    req_gnt    <= '0;
                    last_grant <= win;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
